// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the instruction encoder: class codes, opcode constants
// and FSM state encoding.
package instr_encoder_pkg;

    typedef enum logic [2:0] {
        ClsRtype = 3'd0,
        ClsAddi  = 3'd1,
        ClsSlti  = 3'd2,
        ClsLw    = 3'd3,
        ClsSw    = 3'd4,
        ClsBeq   = 3'd5
    } cls_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpSlti  = 6'b001010;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccept = 2'd1,
        StWrite  = 2'd2
    } state_e;

endpackage

// File: rtl/instr_encoder_pack.sv
// Combinational field assembly: class plus fields to a 32-bit instruction word,
// with a flag for the reserved class codes.
module instr_pack
    import instr_encoder_pkg::*;
(
    input  logic [2:0]  cls,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [5:0]  funct,
    input  logic [15:0] imm,
    output logic [31:0] word,
    output logic        illegal
);

    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (cls)
            ClsRtype: word = {OpRtype, rs, rt, rd, 5'b00000, funct};
            ClsAddi:  word = {OpAddi, rs, rt, imm};
            ClsSlti:  word = {OpSlti, rs, rt, imm};
            ClsLw:    word = {OpLw, rs, rt, imm};
            ClsSw:    word = {OpSw, rs, rt, imm};
            ClsBeq:   word = {OpBeq, rs, rt, imm};
            default:  illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Encodes instruction fields and writes them to sequential instruction-memory
// words. Optional illegal-class counter enabled by INSTR_ENCODER_ERRCNT_EN.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [2:0]        cls_i,
    input  logic [4:0]        rs_i,
    input  logic [4:0]        rt_i,
    input  logic [4:0]        rd_i,
    input  logic [5:0]        funct_i,
    input  logic [15:0]       imm_i,
    output logic              we_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [31:0]       data_o,
    output logic              full_o,
    output logic              err_o
`ifdef INSTR_ENCODER_ERRCNT_EN
    ,
    output logic [7:0]        err_cnt_o
`endif
);

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

    state_e            state;
    logic [ADDR_W-1:0] cnt;
    logic [31:0]       word;
    logic              illegal;
    logic              accept;

    instr_pack u_pack (
        .cls     (cls_i),
        .rs      (rs_i),
        .rt      (rt_i),
        .rd      (rd_i),
        .funct   (funct_i),
        .imm     (imm_i),
        .word    (word),
        .illegal (illegal)
    );

    assign ready_o = (state == StAccept) && !full_o;
    assign accept  = valid_i && ready_o;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state  <= StIdle;
            cnt    <= '0;
            we_o   <= 1'b0;
            addr_o <= '0;
            data_o <= '0;
            full_o <= 1'b0;
            err_o  <= 1'b0;
        end else if (start_i) begin
            // Start wins over any coincident field set, which is dropped.
            state  <= StAccept;
            cnt    <= '0;
            we_o   <= 1'b0;
            full_o <= 1'b0;
            err_o  <= 1'b0;
        end else begin
            case (state)
                StAccept: begin
                    if (accept) begin
                        if (illegal) begin
                            err_o <= 1'b1;
                        end else begin
                            state  <= StWrite;
                            we_o   <= 1'b1;
                            addr_o <= cnt;
                            data_o <= word;
                        end
                    end
                end
                StWrite: begin
                    state <= StAccept;
                    we_o  <= 1'b0;
                    // Counter parks on the last word; full_o blocks further input.
                    if (cnt == LastAddr) begin
                        full_o <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StIdle:  ;
                default: begin
                    state <= StIdle;
                    we_o  <= 1'b0;
                end
            endcase
        end
    end

`ifdef INSTR_ENCODER_ERRCNT_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            err_cnt_o <= 8'd0;
        end else if (start_i) begin
            err_cnt_o <= 8'd0;
        end else if (accept && illegal && (err_cnt_o != 8'hFF)) begin
            err_cnt_o <= err_cnt_o + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: a default-depth instance and a DEPTH=4 instance
// driven from shared inputs.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        valid = 1'b0;
    logic [2:0]  cls = '0;
    logic [4:0]  rs = '0, rt = '0, rd = '0;
    logic [5:0]  funct = '0;
    logic [15:0] imm = '0;

    logic        ready, we, full, err;
    logic [5:0]  addr;
    logic [31:0] data;
    logic        ready4, we4, full4, err4;
    logic [1:0]  addr4;
    logic [31:0] data4;
`ifdef INSTR_ENCODER_ERRCNT_EN
    logic [7:0]  err_cnt, err_cnt4;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_encoder dut (
        .clk_i (clk), .rst_i (rst), .start_i (start), .valid_i (valid), .ready_o (ready),
        .cls_i (cls), .rs_i (rs), .rt_i (rt), .rd_i (rd), .funct_i (funct), .imm_i (imm),
        .we_o (we), .addr_o (addr), .data_o (data), .full_o (full), .err_o (err)
`ifdef INSTR_ENCODER_ERRCNT_EN
        , .err_cnt_o (err_cnt)
`endif
    );

    instr_encoder #(.DEPTH(4), .ADDR_W(2)) dut4 (
        .clk_i (clk), .rst_i (rst), .start_i (start), .valid_i (valid), .ready_o (ready4),
        .cls_i (cls), .rs_i (rs), .rt_i (rt), .rd_i (rd), .funct_i (funct), .imm_i (imm),
        .we_o (we4), .addr_o (addr4), .data_o (data4), .full_o (full4), .err_o (err4)
`ifdef INSTR_ENCODER_ERRCNT_EN
        , .err_cnt_o (err_cnt4)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Entered and left at 1 time unit after a rising edge.
    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic set_fields(input logic [2:0] c, input logic [4:0] s, input logic [4:0] t,
                              input logic [4:0] d, input logic [5:0] f, input logic [15:0] i);
        cls = c; rs = s; rt = t; rd = d; funct = f; imm = i;
    endtask

    task automatic write_check(input string tag, input logic [31:0] exp_addr,
                               input logic [31:0] exp_data);
        valid = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
        check({tag, "_we"}, 32'(we), 32'd1);
        check({tag, "_addr"}, 32'(addr), exp_addr);
        check({tag, "_data"}, data, exp_data);
        @(posedge clk);
        #1 check({tag, "_we_low"}, 32'(we), 32'd0);
    endtask

    initial begin
        int nw;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_we", 32'(we), 32'd0);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_data", data, 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1 check("idle_ready", 32'(ready), 32'd0);

        // Basic program
        do_start();
        check("start_ready", 32'(ready), 32'd1);
        set_fields(3'd1, 5'd0, 5'd1, 5'd0, 6'd0, 16'h0005);
        write_check("addi", 32'd0, 32'h2001_0005);
        set_fields(3'd3, 5'd1, 5'd2, 5'd0, 6'd0, 16'h0004);
        write_check("lw", 32'd1, 32'h8C22_0004);
        set_fields(3'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'h0000);
        write_check("rtype", 32'd2, 32'h0022_1820);
        set_fields(3'd5, 5'd1, 5'd2, 5'd0, 6'd0, 16'hFFFF);
        write_check("beq", 32'd3, 32'h1022_FFFF);
        set_fields(3'd2, 5'd3, 5'd4, 5'd0, 6'd0, 16'h8000);
        write_check("slti", 32'd4, 32'h2864_8000);
        set_fields(3'd4, 5'd31, 5'd0, 5'd0, 6'd0, 16'h1234);
        write_check("sw", 32'd5, 32'hAFE0_1234);

        // Illegal class
        set_fields(3'd7, 5'd9, 5'd9, 5'd9, 6'd9, 16'h9999);
        valid = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
        check("ill_we", 32'(we), 32'd0);
        check("ill_err", 32'(err), 32'd1);
        check("ill_ready", 32'(ready), 32'd1);
        check("ill_addr_hold", 32'(addr), 32'd5);
        check("ill_data_hold", data, 32'hAFE0_1234);
        set_fields(3'd1, 5'd2, 5'd3, 5'd0, 6'd0, 16'hABCD);
        write_check("after_ill", 32'd6, 32'h2043_ABCD);
        check("err_sticky", 32'(err), 32'd1);

        // Start coincident with valid: fields dropped, status cleared
        set_fields(3'd1, 5'd1, 5'd1, 5'd0, 6'd0, 16'h1111);
        valid = 1'b1;
        do_start();
        valid = 1'b0;
        check("sv_we", 32'(we), 32'd0);
        check("sv_err", 32'(err), 32'd0);
        check("sv_ready", 32'(ready), 32'd1);
        set_fields(3'd3, 5'd4, 5'd5, 5'd0, 6'd0, 16'h0010);
        write_check("sv_next", 32'd0, 32'h8C85_0010);

`ifdef INSTR_ENCODER_ERRCNT_EN
        set_fields(3'd6, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0000);
        valid = 1'b1;
        repeat (3) @(posedge clk);
        #1 valid = 1'b0;
        check("errcnt3", 32'(err_cnt), 32'd3);
        do_start();
        check("errcnt_clr", 32'(err_cnt), 32'd0);
`endif

        // DEPTH=4: back-to-back valid until full
        do_start();
        set_fields(3'd1, 5'd7, 5'd8, 5'd0, 6'd0, 16'h0042);
        valid = 1'b1;
        nw = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (we4) begin
                check("d4_addr", 32'(addr4), 32'(nw));
                check("d4_data", data4, 32'h20E8_0042);
                nw++;
            end
        end
        check("d4_writes", 32'(nw), 32'd4);
        check("d4_full", 32'(full4), 32'd1);
        check("d4_ready", 32'(ready4), 32'd0);
        @(posedge clk);
        #1 valid = 1'b0;
        do_start();
        check("d4_full_clr", 32'(full4), 32'd0);
        valid = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
        check("d4_restart_we", 32'(we4), 32'd1);
        check("d4_restart_addr", 32'(addr4), 32'd0);
        @(posedge clk);
        #1;

        // Reset during WRITE
        set_fields(3'd5, 5'd3, 5'd3, 5'd0, 6'd0, 16'h0007);
        valid = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
        check("rw_we_before", 32'(we), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("rw_we_async", 32'(we), 32'd0);
        check("rw_addr", 32'(addr), 32'd0);
        check("rw_data", data, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rw_post_ready", 32'(ready), 32'd0);
        check("rw_post_we", 32'(we), 32'd0);
        check("rw_post_data", data, 32'd0);
        do_start();
        set_fields(3'd0, 5'd4, 5'd5, 5'd6, 6'h22, 16'h0000);
        write_check("rw_next", 32'd0, 32'h0085_3022);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
